// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and defaults for the bit-serial subtractor
package serial_sub_pkg;

    localparam int WIDTH_DEFAULT = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder used as the serial bit-slice
module full_adder (
    output logic S,
    output logic Cout,
    input  logic A,
    input  logic B,
    input  logic Cin
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial D = A - B, LSB first, one full adder reused over WIDTH cycles
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   D
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    state_t           next_state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_sh;
    logic             carry;
    logic             sum;
    logic             cout;
    logic             last_bit;

    full_adder u_fa (
        .S    (sum),
        .Cout (cout),
        .A    (a_sh[0]),
        .B    (b_sh[0]),
        .Cin  (carry)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid)  next_state = SHIFT;
            SHIFT:   if (last_bit)  next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Subtraction as A + ~B + 1; the final carry-out is the inverted borrow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            d_sh      <= '0;
            carry     <= 1'b0;
            out_valid <= 1'b0;
            D         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= A;
                        b_sh  <= ~B;
                        carry <= 1'b1;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    d_sh  <= {sum, d_sh[WIDTH-1:1]};
                    carry <= cout;
                    cnt   <= cnt + CW'(1);
                    // Final bit is folded in directly so out_valid rises on the WIDTH-th shift edge.
                    if (last_bit) begin
                        D         <= {~cout, sum, d_sh[WIDTH-1:1]};
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
